wb_master_bridge: RTL and testbench

// Upstream feeder for the wishbone crossbar. Converts a valid/ready request/response

---
 rtl/wb_master_bridge_if.sv | 30 +++
 rtl/wb_master_bridge.sv | 221 ++++++++++++++++++++++
 tb/tb_wb_master_bridge.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_master_bridge_if.sv
// Wishbone signal bundle between a bus master (the bridge) and one crossbar master port.
interface wb_bus_t #(
   parameter int TAGSIZE = 2
) ();
   logic               cyc;
   logic               stb;
   logic               we;
   logic [31:0]        adr;
   logic [3:0]         sel;
   logic [31:0]        dat_ms;
   logic [31:0]        dat_sm;
   logic               lock;
   logic               gnt;
   logic               ack;
   logic               err;
   logic               rty;
   logic [TAGSIZE-1:0] tga;
   logic [TAGSIZE-1:0] tgc;
   logic [TAGSIZE-1:0] tgd_ms;

   modport master (
      output cyc, stb, we, adr, sel, dat_ms, lock, tga, tgc, tgd_ms,
      input  gnt, ack, err, rty, dat_sm
   );

   modport slave (
      input  cyc, stb, we, adr, sel, dat_ms, lock, tga, tgc, tgd_ms,
      output gnt, ack, err, rty, dat_sm
   );
endinterface

// File: rtl/wb_master_bridge.sv
// Turns one valid/ready request into a single classic wishbone cycle on a crossbar master
// port, with gnt wait, rty backoff, error/timeout handling and one status-tagged response.
module wb_master_bridge #(
   parameter int TAGSIZE   = 2,
   parameter int MAX_RETRY = 4,
   parameter int BACKOFF   = 2,
   parameter int TIMEOUT   = 255
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic [3:0]  req_sel_i,
   input  logic        req_lock_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic [1:0]  rsp_status_o,
   wb_bus_t.master     wb
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_BUS     = 2'd1,
      S_BACKOFF = 2'd2,
      S_RESP    = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      RSP_OK      = 2'b00,
      RSP_ERR     = 2'b01,
      RSP_RETRY   = 2'b10,
      RSP_TIMEOUT = 2'b11
   } status_t;

   localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int BO_W  = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [TMO_W-1:0] TMO_MAX   = {TMO_W{1'b1}};
   localparam logic [BO_W-1:0]  BO_LAST   = BO_W'(BACKOFF - 1);
   localparam logic [7:0]       RETRY_MAX = 8'(MAX_RETRY);
   localparam logic             TMO_EN    = (TIMEOUT > 0);

   state_t             state_q, state_d;
   logic               cyc_q, cyc_d;
   logic               we_q, we_d;
   logic [31:0]        adr_q, adr_d;
   logic [31:0]        dat_ms_q, dat_ms_d;
   logic [3:0]         sel_q, sel_d;
   logic               lock_req_q, lock_req_d;
   logic               lock_q, lock_d;
   logic [7:0]         retry_cnt_q, retry_cnt_d;
   logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
   logic [BO_W-1:0]    bo_cnt_q, bo_cnt_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [31:0]        rsp_rdata_q, rsp_rdata_d;
   status_t            rsp_status_q, rsp_status_d;

   logic               q_ack, q_err, q_rty, tmo_hit;
   logic               done;
   status_t            done_status;
   logic [31:0]        done_rdata;

   // Slave responses only count while the crossbar actually grants this port.
   assign q_ack   = wb.gnt & wb.ack;
   assign q_err   = wb.gnt & wb.err;
   assign q_rty   = wb.gnt & wb.rty;
   assign tmo_hit = TMO_EN && (tmo_cnt_q == TMO_LAST);

   assign req_ready_o = rstn_i & (state_q == S_IDLE);

   always_comb begin
      // NOTE: every _d starts from its _q, so no path through this block can infer a latch.
      state_d      = state_q;
      cyc_d        = cyc_q;
      we_d         = we_q;
      adr_d        = adr_q;
      dat_ms_d     = dat_ms_q;
      sel_d        = sel_q;
      lock_req_d   = lock_req_q;
      lock_d       = lock_q;
      retry_cnt_d  = retry_cnt_q;
      tmo_cnt_d    = tmo_cnt_q;
      bo_cnt_d     = bo_cnt_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_rdata_d  = rsp_rdata_q;
      rsp_status_d = rsp_status_q;
      done         = 1'b0;
      done_status  = RSP_OK;
      done_rdata   = '0;

      case (state_q)
         S_IDLE: begin
            if (req_valid_i && req_ready_o) begin
               state_d     = S_BUS;
               cyc_d       = 1'b1;
               we_d        = req_we_i;
               adr_d       = req_addr_i;
               dat_ms_d    = req_wdata_i;
               sel_d       = req_sel_i;
               lock_req_d  = req_lock_i;
               lock_d      = req_lock_i;
               retry_cnt_d = '0;
               tmo_cnt_d   = '0;
            end
         end

         S_BUS: begin
            if (tmo_cnt_q != TMO_MAX) begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
            if (q_err) begin
               done        = 1'b1;
               done_status = RSP_ERR;
            end else if (q_ack) begin
               done        = 1'b1;
               done_status = RSP_OK;
               done_rdata  = we_q ? 32'd0 : wb.dat_sm;
            end else if (q_rty) begin
               retry_cnt_d = retry_cnt_q + 8'd1;
               if (retry_cnt_d == RETRY_MAX) begin
                  done        = 1'b1;
                  done_status = RSP_RETRY;
               end else begin
                  // Drop cyc so the crossbar can serve other masters during backoff.
                  state_d  = S_BACKOFF;
                  cyc_d    = 1'b0;
                  lock_d   = 1'b0;
                  bo_cnt_d = '0;
               end
            end else if (tmo_hit) begin
               done        = 1'b1;
               done_status = RSP_TIMEOUT;
            end
         end

         S_BACKOFF: begin
            if (bo_cnt_q == BO_LAST) begin
               state_d   = S_BUS;
               cyc_d     = 1'b1;
               lock_d    = lock_req_q;
               tmo_cnt_d = '0;
            end else begin
               bo_cnt_d = bo_cnt_q + 1'b1;
            end
         end

         S_RESP: begin
            if (rsp_ready_i) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b0;
            end
         end

         default: state_d = S_IDLE;
      endcase

      if (done) begin
         state_d      = S_RESP;
         cyc_d        = 1'b0;
         lock_d       = 1'b0;
         rsp_valid_d  = 1'b1;
         rsp_status_d = done_status;
         rsp_rdata_d  = done_rdata;
      end
   end

   always_ff @(posedge clk_i) begin
      // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
      if (!rstn_i) begin
         state_q      <= S_IDLE;
         cyc_q        <= 1'b0;
         we_q         <= 1'b0;
         adr_q        <= '0;
         dat_ms_q     <= '0;
         sel_q        <= '0;
         lock_req_q   <= 1'b0;
         lock_q       <= 1'b0;
         retry_cnt_q  <= '0;
         tmo_cnt_q    <= '0;
         bo_cnt_q     <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= '0;
         rsp_status_q <= RSP_OK;
      end else begin
         state_q      <= state_d;
         cyc_q        <= cyc_d;
         we_q         <= we_d;
         adr_q        <= adr_d;
         dat_ms_q     <= dat_ms_d;
         sel_q        <= sel_d;
         lock_req_q   <= lock_req_d;
         lock_q       <= lock_d;
         retry_cnt_q  <= retry_cnt_d;
         tmo_cnt_q    <= tmo_cnt_d;
         bo_cnt_q     <= bo_cnt_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_status_q <= rsp_status_d;
      end
   end

   assign wb.cyc    = cyc_q;
   assign wb.stb    = cyc_q;
   assign wb.we     = we_q;
   assign wb.adr    = adr_q;
   assign wb.sel    = sel_q;
   assign wb.dat_ms = dat_ms_q;
   assign wb.lock   = lock_q;
   assign wb.tga    = {TAGSIZE{1'b0}};
   assign wb.tgc    = {TAGSIZE{1'b0}};
   assign wb.tgd_ms = {TAGSIZE{1'b0}};

   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_rdata_o  = rsp_rdata_q;
   assign rsp_status_o = rsp_status_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge: a vector table of single transactions plus
// hand-written sequences for latency, retry/backoff, timeout, no-bypass and reset.
module tb_wb_master_bridge;

   logic        clk;
   logic        rstn;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_sel;
   logic        req_lock;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_status;

   int checks = 0;
   int errors = 0;

   wb_bus_t #(.TAGSIZE(2)) wb_if ();

   wb_master_bridge #(
      .TAGSIZE  (2),
      .MAX_RETRY(4),
      .BACKOFF  (2),
      .TIMEOUT  (8)
   ) dut (
      .clk_i       (clk),
      .rstn_i      (rstn),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_we_i    (req_we),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .req_sel_i   (req_sel),
      .req_lock_i  (req_lock),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_rdata_o (rsp_rdata),
      .rsp_status_o(rsp_status),
      .wb          (wb_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  sel;
      logic        lock;
      int          gnt_wait;
      logic        ack;
      logic        err;
      logic [31:0] dat_sm;
      int          hold;
      logic [1:0]  exp_status;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic slave_idle();
      wb_if.gnt    = 1'b0;
      wb_if.ack    = 1'b0;
      wb_if.err    = 1'b0;
      wb_if.rty    = 1'b0;
      wb_if.dat_sm = '0;
   endtask

   task automatic retire(input string name);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check({name, "_retired"}, rsp_valid, 1'b0);
      check({name, "_ready_again"}, req_ready, 1'b1);
   endtask

   // One request through a slave that grants after gnt_wait cycles and answers once.
   task automatic do_txn(input vec_t v, input int idx);
      string nm;
      nm = $sformatf("v%0d", idx);
      @(negedge clk);
      check({nm, "_req_ready"}, req_ready, 1'b1);
      req_valid = 1'b1;
      req_we    = v.we;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      req_sel   = v.sel;
      req_lock  = v.lock;
      @(negedge clk);
      req_valid = 1'b0;
      req_addr  = 32'hFFFF_FFFF;
      req_wdata = 32'hFFFF_FFFF;
      for (int i = 0; i < v.gnt_wait; i++) begin
         check({nm, "_cyc_wait"}, wb_if.cyc, 1'b1);
         slave_idle();
         @(negedge clk);
      end
      check({nm, "_cyc"}, wb_if.cyc, 1'b1);
      check({nm, "_stb"}, wb_if.stb, 1'b1);
      check({nm, "_we"}, wb_if.we, v.we);
      check({nm, "_adr"}, wb_if.adr, v.addr);
      check({nm, "_sel"}, wb_if.sel, v.sel);
      check({nm, "_lock"}, wb_if.lock, v.lock);
      if (v.we) check({nm, "_dat_ms"}, wb_if.dat_ms, v.wdata);
      wb_if.gnt    = 1'b1;
      wb_if.ack    = v.ack;
      wb_if.err    = v.err;
      wb_if.dat_sm = v.dat_sm;
      @(negedge clk);
      slave_idle();
      check({nm, "_cyc_drop"}, wb_if.cyc, 1'b0);
      check({nm, "_lock_drop"}, wb_if.lock, 1'b0);
      check({nm, "_rsp_valid"}, rsp_valid, 1'b1);
      check({nm, "_status"}, rsp_status, v.exp_status);
      check({nm, "_rdata"}, rsp_rdata, v.exp_rdata);
      for (int i = 0; i < v.hold; i++) begin
         @(negedge clk);
         check({nm, "_hold_valid"}, rsp_valid, 1'b1);
         check({nm, "_hold_status"}, rsp_status, v.exp_status);
         check({nm, "_hold_rdata"}, rsp_rdata, v.exp_rdata);
      end
      retire(nm);
   endtask

   // Slave answers rty on the first cycle of each cyc pulse up to n_rty, then ack.
   task automatic retry_seq(input string nm, input int n_rty, input int exp_pulses,
                            input logic [1:0] exp_status, input logic [31:0] exp_rdata);
      int   pulses;
      int   gap;
      int   cycles;
      logic prev_cyc;
      logic done;
      pulses   = 0;
      gap      = 0;
      cycles   = 0;
      prev_cyc = 1'b0;
      done     = 1'b0;
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 32'h0000_0080;
      req_sel   = 4'hF;
      req_lock  = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      while (!done && cycles < 60) begin
         cycles++;
         if (wb_if.cyc && !prev_cyc) begin
            pulses++;
            if (pulses > 1) check({nm, "_backoff_gap"}, gap, 2);
            gap = 0;
         end
         if (!wb_if.cyc && !rsp_valid) gap++;
         if (rsp_valid) done = 1'b1;
         prev_cyc = wb_if.cyc;
         if (wb_if.cyc) begin
            wb_if.gnt    = 1'b1;
            wb_if.rty    = (pulses <= n_rty);
            wb_if.ack    = (pulses > n_rty);
            wb_if.dat_sm = 32'hCAFE_0001;
         end else begin
            slave_idle();
         end
         if (!done) @(negedge clk);
      end
      check({nm, "_completed"}, done, 1'b1);
      check({nm, "_pulses"}, pulses, exp_pulses);
      check({nm, "_status"}, rsp_status, exp_status);
      check({nm, "_rdata"}, rsp_rdata, exp_rdata);
      retire(nm);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int bus_cycles;
      int n;

      rstn      = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_sel   = '0;
      req_lock  = 1'b0;
      rsp_ready = 1'b0;
      slave_idle();

      vecs[0] = '{we:1'b0, addr:32'h0000_0010, wdata:32'h0, sel:4'hF, lock:1'b0, gnt_wait:1,
                  ack:1'b1, err:1'b0, dat_sm:32'hDEAD_BEEF, hold:0, exp_status:2'b00,
                  exp_rdata:32'hDEAD_BEEF};
      vecs[1] = '{we:1'b1, addr:32'h0000_0020, wdata:32'h1234_5678, sel:4'b0011, lock:1'b0,
                  gnt_wait:2, ack:1'b1, err:1'b0, dat_sm:32'hFFFF_FFFF, hold:0,
                  exp_status:2'b00, exp_rdata:32'h0};
      vecs[2] = '{we:1'b0, addr:32'h0000_0040, wdata:32'h0, sel:4'hF, lock:1'b0, gnt_wait:0,
                  ack:1'b0, err:1'b1, dat_sm:32'hAAAA_5555, hold:0, exp_status:2'b01,
                  exp_rdata:32'h0};
      vecs[3] = '{we:1'b0, addr:32'h0000_0044, wdata:32'h0, sel:4'b1100, lock:1'b0, gnt_wait:0,
                  ack:1'b1, err:1'b1, dat_sm:32'h7777_7777, hold:5, exp_status:2'b01,
                  exp_rdata:32'h0};
      vecs[4] = '{we:1'b0, addr:32'h0000_1000, wdata:32'h0, sel:4'hF, lock:1'b1, gnt_wait:3,
                  ack:1'b1, err:1'b0, dat_sm:32'h0BAD_F00D, hold:2, exp_status:2'b00,
                  exp_rdata:32'h0BAD_F00D};
      vecs[5] = '{we:1'b1, addr:32'hFFFF_FFFC, wdata:32'hA5A5_A5A5, sel:4'b1000, lock:1'b1,
                  gnt_wait:0, ack:1'b0, err:1'b1, dat_sm:32'h1111_1111, hold:0,
                  exp_status:2'b01, exp_rdata:32'h0};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_req_ready", req_ready, 1'b0);
      check("rst_cyc", wb_if.cyc, 1'b0);
      check("rst_stb", wb_if.stb, 1'b0);
      check("rst_we", wb_if.we, 1'b0);
      check("rst_lock", wb_if.lock, 1'b0);
      check("rst_adr", wb_if.adr, 32'h0);
      check("rst_tags", {wb_if.tga, wb_if.tgc, wb_if.tgd_ms}, 32'h0);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rsp_status", rsp_status, 2'b00);
      check("rst_rsp_rdata", rsp_rdata, 32'h0);
      rstn = 1'b1;
      @(negedge clk);
      check("post_rst_req_ready", req_ready, 1'b1);

      // Latency: accept T0, cyc T1, gnt+ack T2, rsp_valid T3
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 32'h0000_0010;
      req_sel   = 4'hF;
      @(negedge clk);
      req_valid = 1'b0;
      check("lat_t1_cyc", wb_if.cyc, 1'b1);
      check("lat_t1_req_ready", req_ready, 1'b0);
      check("lat_t1_rsp_valid", rsp_valid, 1'b0);
      @(negedge clk);
      wb_if.gnt    = 1'b1;
      wb_if.ack    = 1'b1;
      wb_if.dat_sm = 32'hDEAD_BEEF;
      @(negedge clk);
      slave_idle();
      check("lat_t3_cyc", wb_if.cyc, 1'b0);
      check("lat_t3_rsp_valid", rsp_valid, 1'b1);
      check("lat_t3_rdata", rsp_rdata, 32'hDEAD_BEEF);
      check("lat_t3_status", rsp_status, 2'b00);
      retire("lat");

      for (int i = 0; i < 6; i++) do_txn(vecs[i], i);

      retry_seq("rty3", 3, 4, 2'b00, 32'hCAFE_0001);
      retry_seq("rty4", 4, 4, 2'b10, 32'h0);

      // Timeout: gnt withheld, ack while gnt=0 must be ignored
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 32'h0000_0090;
      @(negedge clk);
      req_valid    = 1'b0;
      wb_if.gnt    = 1'b0;
      wb_if.ack    = 1'b1;
      wb_if.dat_sm = 32'h9999_9999;
      bus_cycles   = 0;
      n            = 0;
      while (!rsp_valid && n < 30) begin
         if (wb_if.cyc) bus_cycles++;
         n++;
         @(negedge clk);
      end
      slave_idle();
      check("tmo_rsp_valid", rsp_valid, 1'b1);
      check("tmo_bus_cycles", bus_cycles, 8);
      check("tmo_status", rsp_status, 2'b11);
      check("tmo_rdata", rsp_rdata, 32'h0);
      check("tmo_cyc", wb_if.cyc, 1'b0);
      retire("tmo");

      // Response retire and new request in the same cycle: no bypass
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 32'h0000_00A0;
      @(negedge clk);
      req_valid = 1'b0;
      wb_if.gnt = 1'b1;
      wb_if.ack = 1'b1;
      wb_if.dat_sm = 32'h0000_00AA;
      @(negedge clk);
      slave_idle();
      check("nb_rsp_valid", rsp_valid, 1'b1);
      check("nb_rdata", rsp_rdata, 32'h0000_00AA);
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      req_addr  = 32'h0000_00B0;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("nb_retired", rsp_valid, 1'b0);
      check("nb_not_accepted_cyc", wb_if.cyc, 1'b0);
      check("nb_req_ready", req_ready, 1'b1);
      @(negedge clk);
      req_valid = 1'b0;
      check("nb_accept_cyc", wb_if.cyc, 1'b1);
      check("nb_accept_adr", wb_if.adr, 32'h0000_00B0);
      wb_if.gnt    = 1'b1;
      wb_if.ack    = 1'b1;
      wb_if.dat_sm = 32'h0000_0055;
      @(negedge clk);
      slave_idle();
      check("nb2_rdata", rsp_rdata, 32'h0000_0055);
      retire("nb2");

      // Reset in BUS cycle 2, with ack offered in the same cycle
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 32'h0000_00C0;
      req_wdata = 32'h0BEE_F00D;
      @(negedge clk);
      req_valid = 1'b0;
      check("mrst_bus1_cyc", wb_if.cyc, 1'b1);
      @(negedge clk);
      check("mrst_bus2_cyc", wb_if.cyc, 1'b1);
      rstn      = 1'b0;
      wb_if.gnt = 1'b1;
      wb_if.ack = 1'b1;
      @(negedge clk);
      check("mrst_cyc", wb_if.cyc, 1'b0);
      check("mrst_stb", wb_if.stb, 1'b0);
      check("mrst_rsp_valid", rsp_valid, 1'b0);
      check("mrst_req_ready_low", req_ready, 1'b0);
      rstn = 1'b1;
      slave_idle();
      @(negedge clk);
      check("mrst_req_ready", req_ready, 1'b1);
      check("mrst_no_rsp", rsp_valid, 1'b0);
      @(negedge clk);
      check("mrst_no_rsp_later", rsp_valid, 1'b0);
      check("mrst_idle_cyc", wb_if.cyc, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
